// File: rtl/store_buffer.sv
// Posted-store FIFO between the write stage and a single-master memory bus.
// Stores drain in acceptance order; a word-address snoop flags pending RAW hazards.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        address_enable,
    input  logic [31:0] address,
    input  logic [31:0] data,
    output logic        data_valid,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [31:0] bus_writedata,
    input  logic        bus_waitrequest,
    input  logic [31:0] snoop_address,
    output logic        snoop_hit,
    output logic        empty,
    output logic        full
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept, pop;

    // Byte-offset bits carry no meaning for word-granular stores and snoops.
    logic unused_bits;
    assign unused_bits = ^{address[1:0], snoop_address[1:0]};

    assign empty         = (count_q == '0);
    assign full          = (count_q == FULL_CNT);
    assign data_valid    = reset_n && address_enable && !full;
    assign accept        = data_valid;
    assign bus_write     = !empty;
    assign pop           = bus_write && !bus_waitrequest;
    assign bus_address   = {addr_q[head_q], 2'b00};
    assign bus_writedata = data_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            head_d          = head_q + 1'b1;
            valid_d[head_q] = 1'b0;
        end
        if (accept) begin
            tail_d          = tail_q + 1'b1;
            valid_d[tail_q] = 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // The entry being accepted this cycle is not yet in valid_q, so it never hits.
    always_comb begin
        snoop_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == snoop_address[31:2])) begin
                snoop_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            if (accept) begin
                addr_q[tail_q] <= address[31:2];
                data_q[tail_q] <= data;
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: accept, fill/full, streaming, snoop, wrap and async reset.
module tb_store_buffer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        address_enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        data_valid;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [31:0] bus_writedata;
    logic        bus_waitrequest;
    logic [31:0] snoop_address;
    logic        snoop_hit;
    logic        empty;
    logic        full;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_d[$];
    logic [31:0] got_a[$];

    store_buffer #(.DEPTH(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .address_enable (address_enable),
        .address        (address),
        .data           (data),
        .data_valid     (data_valid),
        .bus_write      (bus_write),
        .bus_address    (bus_address),
        .bus_writedata  (bus_writedata),
        .bus_waitrequest(bus_waitrequest),
        .snoop_address  (snoop_address),
        .snoop_hit      (snoop_hit),
        .empty          (empty),
        .full           (full)
    );

    always #5 clock = ~clock;

    // Record completed transfers mid-cycle, when bus signals are settled.
    always @(negedge clock) begin
        if (reset_n && bus_write && !bus_waitrequest) begin
            got_d.push_back(bus_writedata);
            got_a.push_back(bus_address);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain_wait(input string tag, input int max_cycles);
        int n = 0;
        while (!empty && n < max_cycles) begin
            step();
            n++;
        end
        #1;
        chk(tag, {31'd0, empty}, 32'd1);
    endtask

    task automatic idle_inputs();
        address_enable = 1'b0;
        address        = '0;
        data           = '0;
    endtask

    initial begin
        reset_n         = 1'b0;
        bus_waitrequest = 1'b0;
        snoop_address   = '0;
        idle_inputs();
        #12;
        chk("rst_empty",      {31'd0, empty},      32'd1);
        chk("rst_full",       {31'd0, full},       32'd0);
        chk("rst_bus_write",  {31'd0, bus_write},  32'd0);
        chk("rst_bus_addr",   bus_address,         32'd0);
        chk("rst_bus_wdata",  bus_writedata,       32'd0);
        chk("rst_snoop",      {31'd0, snoop_hit},  32'd0);
        address_enable = 1'b1;
        #1;
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        address_enable = 1'b0;
        reset_n = 1'b1;
        step();

        // Single store, no wait states
        address_enable = 1'b1; address = 32'h0000_1003; data = 32'hDEAD_BEEF;
        #1;
        chk("single_dv", {31'd0, data_valid}, 32'd1);
        chk("single_no_bypass", {31'd0, bus_write}, 32'd0);
        step();
        idle_inputs();
        #1;
        chk("single_bw",    {31'd0, bus_write}, 32'd1);
        chk("single_baddr", bus_address,        32'h0000_1000);
        chk("single_bdata", bus_writedata,      32'hDEAD_BEEF);
        step();
        #1;
        chk("single_empty", {31'd0, empty},     32'd1);
        chk("single_bw0",   {31'd0, bus_write}, 32'd0);
        chk("single_count", got_d.size(),       32'd1);
        got_d.delete(); got_a.delete();

        // Fill to full while the bus stalls, then release
        bus_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address_enable = 1'b1; address = 32'h2000 + 32'(4 * i); data = 32'(i + 1);
            #1;
            chk($sformatf("fill_dv%0d", i), {31'd0, data_valid}, 32'd1);
            step();
        end
        address = 32'h2010; data = 32'd5;
        #1;
        chk("fill_full",    {31'd0, full},       32'd1);
        chk("fill_dv_held", {31'd0, data_valid}, 32'd0);
        chk("fill_head",    bus_writedata,       32'd1);
        step();
        #1;
        chk("fill_dv_held2", {31'd0, data_valid}, 32'd0);
        bus_waitrequest = 1'b0;
        #1;
        chk("fill_no_accept_on_pop", {31'd0, data_valid}, 32'd0);
        step();
        #1;
        chk("fill_after_pop_dv",   {31'd0, data_valid}, 32'd1);
        chk("fill_after_pop_full", {31'd0, full},       32'd0);
        step();
        idle_inputs();
        drain_wait("fill_drain", 20);
        chk("fill_n", got_d.size(), 32'd5);
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            chk($sformatf("fill_d%0d", i), got_d[i], 32'(i + 1));
            chk($sformatf("fill_a%0d", i), got_a[i], 32'h2000 + 32'(4 * i));
        end
        got_d.delete(); got_a.delete();

        // Steady stream: one request per cycle, one drain per cycle
        for (int i = 0; i < 10; i++) begin
            address_enable = 1'b1; address = 32'h4000 + 32'(4 * i); data = 32'h100 + 32'(i);
            #1;
            chk($sformatf("stream_dv%0d", i), {31'd0, data_valid}, 32'd1);
            if (i > 0) begin
                chk($sformatf("stream_head%0d", i), bus_writedata, 32'h100 + 32'(i - 1));
            end
            step();
        end
        idle_inputs();
        drain_wait("stream_drain", 5);
        chk("stream_n", got_d.size(), 32'd10);
        for (int i = 0; i < 10 && i < got_d.size(); i++) begin
            chk($sformatf("stream_d%0d", i), got_d[i], 32'h100 + 32'(i));
        end
        got_d.delete(); got_a.delete();

        // Snoop against pending entries
        bus_waitrequest = 1'b1;
        snoop_address = 32'h100;
        address_enable = 1'b1; address = 32'h100; data = 32'hAAAA_0001;
        #1;
        chk("snoop_accepting_excluded", {31'd0, snoop_hit}, 32'd0);
        step();
        address = 32'h204; data = 32'hAAAA_0002;
        step();
        idle_inputs();
        snoop_address = 32'h207; #1;
        chk("snoop_207", {31'd0, snoop_hit}, 32'd1);
        snoop_address = 32'h208; #1;
        chk("snoop_208", {31'd0, snoop_hit}, 32'd0);
        snoop_address = 32'h100; #1;
        chk("snoop_100", {31'd0, snoop_hit}, 32'd1);
        bus_waitrequest = 1'b0;
        drain_wait("snoop_drain", 5);
        chk("snoop_100_drained", {31'd0, snoop_hit}, 32'd0);
        got_d.delete(); got_a.delete();

        // Wrap-around with alternating stalls
        begin
            int acc = 0;
            int cyc = 0;
            while ((acc < 9 || !empty) && cyc < 100) begin
                bus_waitrequest = (cyc % 2 == 0);
                address_enable  = (acc < 9);
                address         = 32'h6000 + 32'(4 * acc);
                data            = 32'h500 + 32'(acc);
                #1;
                if (data_valid) acc++;
                step();
                cyc++;
            end
            idle_inputs();
            bus_waitrequest = 1'b0;
            #1;
            chk("wrap_accepted", 32'(acc), 32'd9);
            chk("wrap_empty", {31'd0, empty}, 32'd1);
            chk("wrap_n", got_d.size(), 32'd9);
            for (int i = 0; i < 9 && i < got_d.size(); i++) begin
                chk($sformatf("wrap_d%0d", i), got_d[i], 32'h500 + 32'(i));
            end
        end
        got_d.delete(); got_a.delete();

        // Asynchronous reset mid-operation
        bus_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address_enable = 1'b1; address = 32'h7000 + 32'(4 * i); data = 32'h900 + 32'(i);
            step();
        end
        idle_inputs();
        snoop_address = 32'h7000;
        #1;
        chk("mid_bw_before",    {31'd0, bus_write}, 32'd1);
        chk("mid_snoop_before", {31'd0, snoop_hit}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_bw_rst",    {31'd0, bus_write}, 32'd0);
        chk("mid_empty_rst", {31'd0, empty},     32'd1);
        chk("mid_snoop_rst", {31'd0, snoop_hit}, 32'd0);
        #1;
        reset_n = 1'b1;
        bus_waitrequest = 1'b0;
        step(); step(); step();
        chk("mid_no_stale", got_d.size(), 32'd0);
        address_enable = 1'b1; address = 32'h3000; data = 32'h77;
        #1;
        chk("mid_new_dv", {31'd0, data_valid}, 32'd1);
        step();
        idle_inputs();
        #1;
        chk("mid_new_addr",  bus_address,   32'h3000);
        chk("mid_new_wdata", bus_writedata, 32'h77);
        drain_wait("mid_drain", 5);
        chk("mid_new_n", got_d.size(), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the write stage and consumes its memory-store request (address_enable, address, data).
- Returns data_valid, which releases the write-stage hold.
- Posts accepted stores into a DEPTH-entry FIFO, then drains them in order to a single-master memory bus with waitrequest flow control.
- Exposes a word-address snoop so load logic can detect read-after-write hazards against stores still pending.

Parameters:
DEPTH, 4, number of posted-store entries; power of two, minimum 2.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset_n  input  1  asynchronous active-low reset.
address_enable  input  1  write stage requests a store this cycle.
address  input  32  store byte address from write stage.
data  input  32  store data from write stage.
data_valid  output  1  store accepted this cycle; write stage releases hold.
bus_write  output  1  bus write request.
bus_address  output  32  bus word address; bits [1:0] always 0.
bus_writedata  output  32  bus write data.
bus_waitrequest  input  1  bus stall; transfer completes on a cycle with bus_write=1 and bus_waitrequest=0.
snoop_address  input  32  load address to check against pending stores.
snoop_hit  output  1  some valid entry has word address equal to snoop_address[31:2].
empty  output  1  no stores pending (count==0).
full  output  1  count==DEPTH.

Behaviour:
- Reset (async, reset_n=0):
  - All FIFO entries are invalidated; head, tail and count are cleared to 0.
  - Outputs are driven to: data_valid=0, bus_write=0, bus_address=0, bus_writedata=0, snoop_hit=0, empty=1, full=0.
  - A bus transfer in progress is abandoned; bus_write drops asynchronously.
- Accept:
  - data_valid = reset_n && address_enable && !full. This is combinational and has zero-cycle latency.
  - On that clock edge, {address[31:2],data} is written at tail, tail increments modulo DEPTH, and count increments.
  - The write stage advances on the same edge, so each request is accepted exactly once. A new request in the next cycle is a new store.
- Full:
  - No accept while full, even if the head pops in the same cycle.
  - The pop frees a slot, and accept resumes the following cycle.
  - data_valid stays 0 and the write stage holds, with address and data stable.
- Drain:
  - bus_write = !empty.
  - bus_address = {head.addr,2'b00} and bus_writedata = head.data, both driven straight from the head entry registers.
  - Bus outputs are stable while bus_waitrequest=1.
  - Pop on an edge where bus_write && !bus_waitrequest: head increments modulo DEPTH and count decrements.
  - A transfer takes a minimum of one cycle. With bus_waitrequest=0, back-to-back entries drain at one per cycle.
- Simultaneous accept and pop (not full): count is unchanged, head and tail both advance, and ordering is preserved.
- Accept into an empty buffer: the entry appears on the bus the next cycle. There is no bypass from the input to the bus.
- Wrap-around: head and tail are log2(DEPTH)-bit indices that wrap naturally. count is log2(DEPTH)+1 bits wide so that full can be distinguished from empty.
- Alignment: address[1:0] is discarded. No byte enables and no misalignment fault are generated.
- Snoop:
  - Combinational OR over valid entries, comparing entry.addr with snoop_address[31:2].
  - The entry being accepted this cycle is not included. The entry being popped this cycle is included until the edge.
- Ordering: stores reach the bus strictly in acceptance order. Duplicate addresses are kept as separate entries with no merging.

Test Plan:
- Single store, bus_waitrequest=0: address=0x0000_1003, data=0xDEADBEEF, address_enable for 1 cycle.
  - Required: data_valid=1 in that cycle.
  - Next cycle: bus_write=1, bus_address=0x0000_1000, bus_writedata=0xDEADBEEF.
  - The cycle after: empty=1, bus_write=0.
- Fill with bus_waitrequest=1: 5 consecutive requests (data 1..5) with DEPTH=4.
  - Required: data_valid=1 for 4 cycles, then full=1 and data_valid=0 with request 5 held.
  - Release waitrequest: request 5 is accepted one cycle after the first pop.
  - The bus shows data 1,2,3,4,5 in order.
- Steady stream with waitrequest=0: a new request every cycle for 10 cycles.
  - Required: count never exceeds 1, data_valid=1 every cycle, and 10 bus writes occur in order.
- Snoop: entries at 0x100 and 0x204 pending with waitrequest=1.
  - snoop_address=0x207 -> snoop_hit=1.
  - snoop_address=0x208 -> snoop_hit=0.
  - After both entries drain, snoop_address=0x100 -> snoop_hit=0.
- Wrap-around: 9 stores with waitrequest toggled 1,0 each cycle.
  - Required: all 9 reach the bus in order and empty=1 at the end.
- Reset mid-operation: 3 entries pending, bus_write=1, waitrequest=1; pulse reset_n low between clock edges.
  - Required: bus_write=0, empty=1, snoop_hit=0 immediately.
  - After release: no stale bus writes, and a new store is accepted normally.
